axis_split_send_xc: RTL
=======================

Name: axis_split_send_xc

Overview:
- Host-to-chip send path; the counterpart of the PAICORE receive join.
- Accepts 64-bit AXI-Stream frames from the host DMA FIFO and distributes whole frames round-robin over enabled PAICORE input channels.
- Each frame is split into two 32-bit words. Each word is delivered with a 4-phase request/acknowledge handshake per channel.
- Channels run independently, so up to Channel frames are in flight at once.

Parameters:
- Channel, 4, number of PAICORE input channels.
- DATA_WIDTH, 64, AXIS data width; fixed at 2×32 and not otherwise supported.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- oen  in  Channel  per-channel output enable; bit i=1 lets channel i receive frames.
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready.
- s_axis_tdata  in  64  AXIS frame.
- s_axis_tlast  in  1  marks the last frame of a transfer.
- request  out  Channel  4-phase request to chip, one bit per channel.
- dout  out  Channel*32  word to chip; channel i occupies [32i+31:32i].
- acknowledge  in  Channel  4-phase acknowledge from chip; asynchronous to clk.
- send_hsked  out  1  one-cycle pulse per accepted AXIS beat.
- frame_cnt  out  32  count of accepted beats since reset; wraps modulo 2^32.
- tx_busy  out  1  high while any channel is active or a tlast is pending.
- o_tx_done  out  1  one-cycle pulse after the tlast frame has fully handshaken.

Behaviour:
- Reset values: s_axis_tready=0 while rst. request=0, dout=0, send_hsked=0, frame_cnt=0, tx_busy=0, o_tx_done=0. RR pointer=0, all channel FSMs IDLE, pending_last=0.
- Reset mid-operation: request drops at the next edge and in-flight words are discarded.
- Acknowledge synchronization: each bit passes through 2 flops (reset 0). FSMs use only ack_s.
- Channel FSM (per channel):
  - IDLE: on load, latch hi=tdata[63:32] and lo=tdata[31:0], go to HI_REQ.
  - HI_REQ: request=1, dout=hi; ack_s=1 -> HI_RET.
  - HI_RET: request=0; ack_s=0 -> LO_REQ.
  - LO_REQ: request=1, dout=lo; ack_s=1 -> LO_RET.
  - LO_RET: request=0; ack_s=0 -> IDLE.
  - request and dout are registered. dout changes only while request=0 or on the edge where request rises. dout holds the last word while the channel is IDLE.
- Dispatcher:
  - sel = first channel c scanned cyclically from the RR pointer with oen[c]=1 and FSM(c)=IDLE.
  - s_axis_tready=1 iff such a channel exists and rst=0. Computed combinationally from registered state only; it does not depend on tvalid.
  - On tvalid&tready: load sel, set pointer to (sel+1) mod Channel, pulse send_hsked, increment frame_cnt.
- Latency: beat accepted at edge T -> request high after edge T+1. Minimum time per frame on one channel is bounded by chip ack response plus 2-cycle sync per phase.
- Enable rules:
  - oen=0: tready held 0.
  - Clearing oen[i] while channel i is busy: the current frame completes, and no new frames go to channel i.
- tlast handling:
  - An accepted beat with tlast sets pending_last.
  - o_tx_done pulses for one cycle on the first cycle where pending_last=1, all FSMs are IDLE and no load occurs. pending_last clears on the same edge.
  - A tlast beat accepted while pending_last is already 1 keeps pending_last=1, giving a single done pulse.
- Ordering: frames are ordered per channel only. No ordering is guaranteed across channels.
- Acknowledge high while a channel is IDLE is ignored. The FSM waits for ack_s=0 only in the *_RET states.

Test Plan:
- Reset then oen=4'b0001; send frame 0x11112222_33334444 with tlast, ack responds 3 cycles after each edge -> ch0 dout=0x11112222 then 0x33334444; request makes 2 full 4-phase cycles; send_hsked=1 once; frame_cnt=1; o_tx_done pulses once after the final ack falls.
- oen=4'hF, 8 back-to-back frames, immediate acks -> frames 0..7 land on channels 0,1,2,3,0,1,2,3; tready stalls only when all 4 channels are busy; frame_cnt=8.
- oen=4'b0101, ack withheld on ch0 -> frames go to ch0 then ch2, after which tready=0; releasing ch0 ack -> next frame goes to ch0.
- oen=0 with tvalid=1 -> tready stays 0 and request stays 0 for 100 cycles.
- Assert rst while ch1 is in LO_REQ -> request=0 and tready=0 after the edge; after release, frame_cnt=0 and a new frame starts cleanly on ch0.
- frame_cnt preloaded near 0xFFFFFFFF by forcing, send 2 beats -> frame_cnt wraps to 0x00000000 and then 0x00000001.

Source files
------------

// File: rtl/axis_split_send_xc.sv
// Host-to-chip send path: splits 64-bit AXIS frames into two 32-bit words and
// hands whole frames round-robin to enabled channels over 4-phase req/ack.
module axis_split_send_xc #(
  parameter int unsigned Channel    = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Channel-1:0]      oen,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic [Channel-1:0]      request,
  output logic [Channel*32-1:0]   dout,
  input  logic [Channel-1:0]      acknowledge,
  output logic                    send_hsked,
  output logic [31:0]             frame_cnt,
  output logic                    tx_busy,
  output logic                    o_tx_done
);

  localparam int unsigned WordW = 32;
  localparam int unsigned PtrW  = (Channel > 1) ? $clog2(Channel) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HI_REQ = 3'd1,
    ST_HI_RET = 3'd2,
    ST_LO_REQ = 3'd3,
    ST_LO_RET = 3'd4
  } state_e;

  state_e                   state_q [Channel];
  state_e                   state_d [Channel];
  logic [WordW-1:0]         hi_q    [Channel];
  logic [WordW-1:0]         hi_d    [Channel];
  logic [WordW-1:0]         lo_q    [Channel];
  logic [WordW-1:0]         lo_d    [Channel];
  logic [Channel-1:0]       request_q, request_d;
  logic [Channel*WordW-1:0] dout_q, dout_d;
  logic [Channel-1:0]       ack_meta_q, ack_meta_d;
  logic [Channel-1:0]       ack_s_q, ack_s_d;
  logic [PtrW-1:0]          rr_q, rr_d;
  logic                     pending_last_q, pending_last_d;
  logic                     send_hsked_q, send_hsked_d;
  logic [31:0]              frame_cnt_q, frame_cnt_d;
  logic                     tx_busy_q, tx_busy_d;
  logic                     o_tx_done_q, o_tx_done_d;

  logic                     found_c;
  logic [PtrW-1:0]          sel_c;
  logic [PtrW-1:0]          idx_c;
  logic                     load_c;
  logic                     all_idle_c;
  logic                     any_busy_c;
  logic                     done_c;

  // Round-robin scan for the first enabled idle channel starting at the pointer.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    idx_c   = '0;
    for (int unsigned k = 0; k < Channel; k++) begin
      idx_c = PtrW'((32'(rr_q) + k) % Channel);
      if (!found_c && oen[idx_c] && (state_q[idx_c] == ST_IDLE)) begin
        found_c = 1'b1;
        sel_c   = idx_c;
      end
    end
  end

  assign s_axis_tready = found_c & ~rst;
  assign load_c        = s_axis_tvalid & s_axis_tready;

  // Per-channel 4-phase word sequencer.
  always_comb begin
    request_d  = '0;
    dout_d     = dout_q;
    ack_meta_d = acknowledge;
    ack_s_d    = ack_meta_q;
    for (int unsigned c = 0; c < Channel; c++) begin
      state_d[c] = state_q[c];
      hi_d[c]    = hi_q[c];
      lo_d[c]    = lo_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (load_c && (sel_c == PtrW'(c))) begin
            hi_d[c]    = s_axis_tdata[DATA_WIDTH-1 -: WordW];
            lo_d[c]    = s_axis_tdata[WordW-1:0];
            state_d[c] = ST_HI_REQ;
          end
        end
        ST_HI_REQ: begin
          request_d[c]                 = ~ack_s_q[c];
          dout_d[c*WordW +: WordW]     = hi_q[c];
          if (ack_s_q[c]) state_d[c]   = ST_HI_RET;
        end
        ST_HI_RET: begin
          if (!ack_s_q[c]) state_d[c]  = ST_LO_REQ;
        end
        ST_LO_REQ: begin
          request_d[c]                 = ~ack_s_q[c];
          dout_d[c*WordW +: WordW]     = lo_q[c];
          if (ack_s_q[c]) state_d[c]   = ST_LO_RET;
        end
        ST_LO_RET: begin
          if (!ack_s_q[c]) state_d[c]  = ST_IDLE;
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  // Dispatcher bookkeeping, counters and transfer-done tracking.
  always_comb begin
    all_idle_c = 1'b1;
    any_busy_c = 1'b0;
    for (int unsigned c = 0; c < Channel; c++) begin
      if (state_q[c] != ST_IDLE) all_idle_c = 1'b0;
      if (state_d[c] != ST_IDLE) any_busy_c = 1'b1;
    end
    done_c         = pending_last_q & all_idle_c & ~load_c;
    pending_last_d = pending_last_q;
    if (done_c)                pending_last_d = 1'b0;
    if (load_c & s_axis_tlast) pending_last_d = 1'b1;
    rr_d         = load_c ? PtrW'((32'(sel_c) + 32'd1) % Channel) : rr_q;
    frame_cnt_d  = frame_cnt_q + 32'(load_c);
    send_hsked_d = load_c;
    tx_busy_d    = any_busy_c | pending_last_d;
    o_tx_done_d  = done_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < Channel; c++) begin
        state_q[c] <= ST_IDLE;
        hi_q[c]    <= '0;
        lo_q[c]    <= '0;
      end
      request_q      <= '0;
      dout_q         <= '0;
      ack_meta_q     <= '0;
      ack_s_q        <= '0;
      rr_q           <= '0;
      pending_last_q <= 1'b0;
      send_hsked_q   <= 1'b0;
      frame_cnt_q    <= '0;
      tx_busy_q      <= 1'b0;
      o_tx_done_q    <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < Channel; c++) begin
        state_q[c] <= state_d[c];
        hi_q[c]    <= hi_d[c];
        lo_q[c]    <= lo_d[c];
      end
      request_q      <= request_d;
      dout_q         <= dout_d;
      ack_meta_q     <= ack_meta_d;
      ack_s_q        <= ack_s_d;
      rr_q           <= rr_d;
      pending_last_q <= pending_last_d;
      send_hsked_q   <= send_hsked_d;
      frame_cnt_q    <= frame_cnt_d;
      tx_busy_q      <= tx_busy_d;
      o_tx_done_q    <= o_tx_done_d;
    end
  end

  assign request    = request_q;
  assign dout       = dout_q;
  assign send_hsked = send_hsked_q;
  assign frame_cnt  = frame_cnt_q;
  assign tx_busy    = tx_busy_q;
  assign o_tx_done  = o_tx_done_q;

endmodule
